// File: rtl/sub_serial.sv
// Bit-serial signed subtractor: S = X - Y computed LSB first as X + ~Y + 1,
// one bit per clock, using a single carry flop and an IDLE/BUSY/DONE FSM.
module sub_serial #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [n-1:0] X,
    input  logic [n-1:0] Y,
    output logic [n:0]   S,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(n + 2);
    localparam logic [CW-1:0] LAST_BIT = CW'(n);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t         state_q, state_d;
    logic [n:0]     x_q, x_d;
    logic [n:0]     y_q, y_d;
    logic [n:0]     res_q, res_d;
    logic [n:0]     s_q, s_d;
    logic           carry_q, carry_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           sum_bit_s;
    logic           carry_out_s;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        res_d       = res_q;
        s_d         = s_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        sum_bit_s   = x_q[0] ^ ~y_q[0] ^ carry_q;
        carry_out_s = (x_q[0] & ~y_q[0]) | (x_q[0] & carry_q) | (~y_q[0] & carry_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    x_d     = {X[n-1], X};
                    y_d     = {Y[n-1], Y};
                    res_d   = '0;
                    carry_d = 1'b1;
                    cnt_d   = '0;
                    state_d = BUSY;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // Operands shift right so bit 0 is always the current bit
                res_d   = {sum_bit_s, res_q[n:1]};
                x_d     = {1'b0, x_q[n:1]};
                y_d     = {1'b0, y_q[n:1]};
                carry_d = carry_out_s;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    s_d     = {sum_bit_s, res_q[n:1]};
                    state_d = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == BUSY);
        done_d = (state_d == DONE);
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            s_q     <= s_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign S    = s_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
